// File: rtl/pc_seq.sv
// pc_seq: microinstruction cycle sequencer driving PC source select, trap force and FETCH strobe.
// Define PC_SEQ_FETCH_COUNT_EN to build the 32-bit FETCH cycle counter on fetch_count.
module pc_seq #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
  input  logic        step,
  input  logic        trap_req,
  input  logic        popj,
  input  logic        jump_take,
  input  logic        dispatch,
  input  logic        mem_wait,
  output logic        state_decode,
  output logic        state_read,
  output logic        state_alu,
  output logic        state_write,
  output logic        state_fetch,
  output logic        pcs1,
  output logic        pcs0,
  output logic        trap,
  output logic        spc_pop,
  output logic        halted,
  output logic        trap_pending,
  output logic [31:0] fetch_count
);

  localparam int unsigned CntW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  // Counter value on the wait cycle that makes it reach WAIT_TIMEOUT.
  localparam logic [CntW-1:0] HitVal = (WAIT_TIMEOUT > 0) ? CntW'(WAIT_TIMEOUT - 1) : '0;

  typedef enum logic [5:0] {
    StHalted = 6'b000001,
    StDecode = 6'b000010,
    StRead   = 6'b000100,
    StAlu    = 6'b001000,
    StWrite  = 6'b010000,
    StFetch  = 6'b100000
  } state_e;

  state_e          state_q;
  logic            halt_seen_q;
  logic            step_one_q;
  logic            trap_pending_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [1:0]      pcs_q;
  logic            trap_q;
  logic            spc_pop_q;

  logic wait_hit;
  logic trap_set;
  logic trap_take;
  logic halt_now;

  assign wait_hit  = (WAIT_TIMEOUT != 0) && (state_q == StWrite) && mem_wait &&
                     (wait_cnt_q == HitVal);
  assign trap_set  = trap_req || wait_hit;
  assign trap_take = trap_pending_q || trap_set;
  assign halt_now  = halt_seen_q || halt_req || !run || step_one_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StHalted;
      halt_seen_q    <= 1'b0;
      step_one_q     <= 1'b0;
      trap_pending_q <= 1'b0;
      wait_cnt_q     <= '0;
      pcs_q          <= 2'b11;
      trap_q         <= 1'b0;
      spc_pop_q      <= 1'b0;
    end else begin
      // A trap serviced by this FETCH clears; a new request in the same cycle re-arms it.
      trap_pending_q <= trap_set || (trap_pending_q && !((state_q == StFetch) && trap_q));

      if ((state_q == StWrite) && mem_wait) begin
        if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end

      pcs_q     <= 2'b11;
      trap_q    <= 1'b0;
      spc_pop_q <= 1'b0;

      if ((state_q != StHalted) && halt_req) halt_seen_q <= 1'b1;

      unique case (state_q)
        StHalted: begin
          if (run && !halt_req) begin
            state_q    <= StDecode;
            step_one_q <= 1'b0;
          end else if (step) begin
            state_q    <= StDecode;
            step_one_q <= 1'b1;
          end
        end
        StDecode: state_q <= StRead;
        StRead:   state_q <= StAlu;
        StAlu:    state_q <= StWrite;
        StWrite: begin
          if (!mem_wait) begin
            state_q <= StFetch;
            if (trap_take) begin
              trap_q <= 1'b1;
            end else if (popj) begin
              pcs_q     <= 2'b00;
              spc_pop_q <= 1'b1;
            end else if (jump_take) begin
              pcs_q <= 2'b01;
            end else if (dispatch) begin
              pcs_q <= 2'b10;
            end
          end
        end
        StFetch: begin
          if (halt_now) begin
            state_q     <= StHalted;
            halt_seen_q <= 1'b0;
            step_one_q  <= 1'b0;
          end else begin
            state_q <= StDecode;
          end
        end
        default: state_q <= StHalted;
      endcase
    end
  end

  assign halted       = state_q[0];
  assign state_decode = state_q[1];
  assign state_read   = state_q[2];
  assign state_alu    = state_q[3];
  assign state_write  = state_q[4];
  assign state_fetch  = state_q[5];
  assign pcs1         = pcs_q[1];
  assign pcs0         = pcs_q[0];
  assign trap         = trap_q;
  assign spc_pop      = spc_pop_q;
  assign trap_pending = trap_pending_q;

`ifdef PC_SEQ_FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
    end else if (state_q == StFetch) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule
